// File: rtl/ysyx_22041412_lsu_pkg.sv
// Shared constants for the load/store unit: opcodes, FSM states, access sizes, byte-mask bases.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ysyx_22041412_lsu_pkg;

  localparam int LSU_XLEN = 64;
  localparam int LSU_RD_W = 5;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  // func3[1:0] is the access size, func3[2] selects zero-extension on loads
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam logic [7:0] WMASK_B = 8'h01;
  localparam logic [7:0] WMASK_H = 8'h03;
  localparam logic [7:0] WMASK_W = 8'h0F;
  localparam logic [7:0] WMASK_D = 8'hFF;

  function automatic logic [7:0] wmask_base(input logic [1:0] sz);
    logic [7:0] m;
    case (sz)
      SZ_B:    m = WMASK_B;
      SZ_H:    m = WMASK_H;
      SZ_W:    m = WMASK_W;
      default: m = WMASK_D;
    endcase
    return m;
  endfunction

  // An access is misaligned when its offset is not a multiple of its size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [2:0] off);
    logic r;
    case (sz)
      SZ_H:    r = off[0];
      SZ_W:    r = (off[1:0] != 2'b00);
      SZ_D:    r = (off != 3'b000);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/ysyx_22041412_lsu_if.sv
// Data-memory bus between the LSU (master) and memory (slave): req/gnt request phase, rvalid read return.
// Latency: n/a (wires only).
// Backpressure: master holds req, we, addr, wdata and wmask stable until gnt; rvalid is never stalled.
// Signals: mem_req/mem_we/mem_addr/mem_wdata/mem_wmask (master->slave), mem_gnt/mem_rvalid/mem_rdata (slave->master).
interface ysyx_22041412_lsu_if
  import ysyx_22041412_lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) ();

  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [7:0]      mem_wmask;
  logic            mem_gnt;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/ysyx_22041412_lsu_align.sv
// Byte-lane alignment: shifts store data / builds the byte mask, and extracts + extends load data.
// Latency: combinational.
// Backpressure: none.
// Ports: func3, offset (addr[2:0]), sdata, rdata in; wdata, wmask, ldata out.
module ysyx_22041412_lsu_align
  import ysyx_22041412_lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [2:0]      func3,
  input  logic [2:0]      offset,
  input  logic [XLEN-1:0] sdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] ldata
);

  logic [XLEN-1:0] lane;

  always_comb begin
    // bytes pushed past lane 7 simply fall off the top
    wmask = wmask_base(func3[1:0]) << offset;
    wdata = sdata << {offset, 3'b000};
    lane  = rdata >> {offset, 3'b000};
    case (func3)
      3'b000:  ldata = {{(XLEN-8){lane[7]}},   lane[7:0]};
      3'b001:  ldata = {{(XLEN-16){lane[15]}}, lane[15:0]};
      3'b010:  ldata = {{(XLEN-32){lane[31]}}, lane[31:0]};
      3'b100:  ldata = {{(XLEN-8){1'b0}},      lane[7:0]};
      3'b101:  ldata = {{(XLEN-16){1'b0}},     lane[15:0]};
      3'b110:  ldata = {{(XLEN-32){1'b0}},     lane[31:0]};
      default: ldata = lane;
    endcase
  end

endmodule

// File: rtl/ysyx_22041412_lsu.sv
// Load/store stage after the ALU: single-outstanding memory access, registered result to write-back.
// Latency: non-mem 1 cycle; store 1 + grant wait + 1; load adds the rvalid wait.
// Backpressure: in_ready only in IDLE or in DONE while out_ready; result held in DONE until out_ready.
// Ports: clk, rst_n; in_* (EX handshake); bus (memory master); out_* (write-back handshake).
// Optional: YSYX_22041412_LSU_MISALIGN_EN adds out_misalign and suppresses bus traffic for misaligned accesses.
module ysyx_22041412_lsu
  import ysyx_22041412_lsu_pkg::*;
#(
  parameter int XLEN = LSU_XLEN,
  parameter int RD_W = LSU_RD_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [6:0]          in_opcode,
  input  logic [2:0]          in_func3,
  input  logic [XLEN-1:0]     in_result,
  input  logic [XLEN-1:0]     in_sdata,
  input  logic [RD_W-1:0]     in_rd,
  ysyx_22041412_lsu_if.master bus,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_data,
  output logic [RD_W-1:0]     out_rd,
  output logic                out_wen
`ifdef YSYX_22041412_LSU_MISALIGN_EN
  ,
  output logic                out_misalign
`endif
);

  lsu_state_e      state;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] sdata_q;
  logic [2:0]      func3_q;
  logic [RD_W-1:0] rd_q;
  logic            req_q;
  logic            we_q;

  logic [XLEN-1:0] wdata_w;
  logic [7:0]      wmask_w;
  logic [XLEN-1:0] ldata_w;

  logic accept;
  logic is_load;
  logic is_store;

  assign in_ready = (state == ST_IDLE) | ((state == ST_DONE) & out_ready);
  assign accept   = in_valid & in_ready;
  assign is_load  = (in_opcode == OP_LOAD);
  assign is_store = (in_opcode == OP_STORE);

  ysyx_22041412_lsu_align #(.XLEN(XLEN)) u_align (
    .func3  (func3_q),
    .offset (addr_q[2:0]),
    .sdata  (sdata_q),
    .rdata  (bus.mem_rdata),
    .wdata  (wdata_w),
    .wmask  (wmask_w),
    .ldata  (ldata_w)
  );

  // store lanes are only presented for writes, so loads and reset show a clean all-zero mask
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = {addr_q[XLEN-1:3], 3'b000};
  assign bus.mem_wdata = we_q ? wdata_w : '0;
  assign bus.mem_wmask = we_q ? wmask_w : 8'h00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      addr_q       <= '0;
      sdata_q      <= '0;
      func3_q      <= '0;
      rd_q         <= '0;
      req_q        <= 1'b0;
      we_q         <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_rd       <= '0;
      out_wen      <= 1'b0;
`ifdef YSYX_22041412_LSU_MISALIGN_EN
      out_misalign <= 1'b0;
`endif
    end else begin
      case (state)
        ST_REQ: begin
          if (bus.mem_gnt) begin
            req_q <= 1'b0;
            if (we_q) begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              out_data  <= '0;
              out_rd    <= rd_q;
              out_wen   <= 1'b0;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.mem_rvalid) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            out_data  <= ldata_w;
            out_rd    <= rd_q;
            out_wen   <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state        <= ST_IDLE;
            out_valid    <= 1'b0;
`ifdef YSYX_22041412_LSU_MISALIGN_EN
            out_misalign <= 1'b0;
`endif
          end
        end
        default: ;
      endcase

      // A new op (from IDLE, or from DONE as the old result drains) overrides the case above.
      if (accept) begin
        rd_q    <= in_rd;
        func3_q <= in_func3;
        if (is_load | is_store) begin
          addr_q  <= in_result;
          sdata_q <= in_sdata;
`ifdef YSYX_22041412_LSU_MISALIGN_EN
          if (is_misaligned(in_func3[1:0], in_result[2:0])) begin
            state        <= ST_DONE;
            out_valid    <= 1'b1;
            out_data     <= '0;
            out_rd       <= in_rd;
            out_wen      <= 1'b0;
            out_misalign <= 1'b1;
          end else begin
            out_misalign <= 1'b0;
`else
          begin
`endif
            state     <= ST_REQ;
            req_q     <= 1'b1;
            we_q      <= is_store;
            out_valid <= 1'b0;
          end
        end else begin
          state     <= ST_DONE;
          out_valid <= 1'b1;
          out_data  <= in_result;
          out_rd    <= in_rd;
          out_wen   <= 1'b1;
`ifdef YSYX_22041412_LSU_MISALIGN_EN
          out_misalign <= 1'b0;
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22041412_lsu.sv
// Bench for ysyx_22041412_lsu: directed cases plus randomized ops against a byte-level reference model.
// Memory is a behavioural responder with random grant/rvalid delays.
module tb_ysyx_22041412_lsu;

  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, in_ready, out_valid, out_ready, out_wen;
  logic [6:0]  in_opcode;
  logic [2:0]  in_func3;
  logic [63:0] in_result, in_sdata, out_data;
  logic [4:0]  in_rd, out_rd;
`ifdef YSYX_22041412_LSU_MISALIGN_EN
  logic        out_misalign;
`endif

  ysyx_22041412_lsu_if #(.XLEN(64)) bus ();

  ysyx_22041412_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_opcode(in_opcode), .in_func3(in_func3),
    .in_result(in_result), .in_sdata(in_sdata), .in_rd(in_rd),
    .bus(bus),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_wen(out_wen)
`ifdef YSYX_22041412_LSU_MISALIGN_EN
    , .out_misalign(out_misalign)
`endif
  );

  int n_checks = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%h exp=0x%h", tag, got, exp);
    end
  endtask

  typedef struct { logic [63:0] data; logic [4:0] rd; logic wen; logic mis; } out_exp_t;
  typedef struct { logic [63:0] addr; logic we; logic [63:0] wdata; logic [7:0] wmask; } bus_exp_t;
  out_exp_t out_q[$];
  bus_exp_t bus_q[$];

  int          fixed_gnt = -1, fixed_rv = -1, rdy_low_next = 0, rs = 0;
  bit          use_fixed = 0, force_rdy = 0;
  logic [63:0] fixed_rdata = '0, last_out_data = '0, last_wdata = '0, last_addr = '0;
  logic [7:0]  last_wmask = '0;
  logic        last_out_wen = 1'b0;

  // ---------------- reference model ----------------
  function automatic logic [63:0] word_for(input logic [63:0] a);
    if (use_fixed) return fixed_rdata;
    return {a[31:0] ^ 32'hC3A5_5A3C, a[31:0] * 32'h9E37_79B9 + 32'h1357_9BDF};
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input int off, input logic [63:0] w);
    int n; logic [63:0] v;
    n = 1 << f3[1:0]; v = '0;
    for (int k = 0; k < n; k++) if (off + k < 8) v[8*k +: 8] = w[8*(off+k) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1]) for (int k = n; k < 8; k++) v[8*k +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [7:0] ref_mask(input logic [2:0] f3, input int off);
    logic [7:0] m; int n;
    n = 1 << f3[1:0];
    for (int i = 0; i < 8; i++) m[i] = (i >= off) && (i < off + n);
    return m;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [63:0] sd, input int off);
    logic [63:0] w;
    for (int i = 0; i < 8; i++) w[8*i +: 8] = (i >= off) ? sd[8*(i-off) +: 8] : 8'h00;
    return w;
  endfunction

  function automatic bit ref_mis(input logic [2:0] f3, input int off);
    return (off % (1 << f3[1:0])) != 0;
  endfunction

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [6:0] opc, input logic [2:0] f3, input logic [63:0] res,
                      input logic [63:0] sd, input logic [4:0] rd);
    bit is_ld, is_st, mis, acc; int off; out_exp_t oe; bus_exp_t be;
    is_ld = (opc == LD); is_st = (opc == ST); off = int'(res[2:0]); mis = 0; acc = 0;
`ifdef YSYX_22041412_LSU_MISALIGN_EN
    if (is_ld || is_st) mis = ref_mis(f3, off);
`endif
    in_valid = 1'b1; in_opcode = opc; in_func3 = f3; in_result = res; in_sdata = sd; in_rd = rd;
    for (int b = 0; b < 200; b++) begin
      @(negedge clk);
      if (in_ready) begin acc = 1; break; end
      @(posedge clk); #1;
    end
    if (!acc) begin
      check_val("accept_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
      return;
    end
    oe.rd = rd; oe.mis = mis;
    be.addr = {res[63:3], 3'b000}; be.we = is_st; be.wdata = '0; be.wmask = '0;
    if (mis) begin
      oe.data = '0; oe.wen = 0;
    end else if (is_ld) begin
      oe.data = ref_load(f3, off, word_for(be.addr)); oe.wen = 1; bus_q.push_back(be);
    end else if (is_st) begin
      be.wdata = ref_wdata(sd, off); be.wmask = ref_mask(f3, off);
      oe.data = '0; oe.wen = 0; bus_q.push_back(be);
    end else begin
      oe.data = res; oe.wen = 1;
    end
    out_q.push_back(oe);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if ((is_ld || is_st) && !mis) check_val("lat_req", {63'd0, bus.mem_req}, 64'd1);
    else check_val("lat_out", {63'd0, out_valid}, 64'd1);
  endtask

  task automatic wait_drain();
    int b = 0;
    while (out_q.size() > 0 && b < 400) begin @(posedge clk); #1; b++; end
    if (b >= 400) check_val("drain_timeout", 64'(out_q.size()), 64'd0);
  endtask

  // ---------------- memory responder ----------------
  initial begin
    int cnt, rvcnt; logic [63:0] raddr; bus_exp_t be;
    cnt = 0; rvcnt = 0; raddr = '0;
    bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = {$urandom, $urandom};
      if (rs == 2) begin
        if (rvcnt == 0) begin bus.mem_rvalid = 1; bus.mem_rdata = word_for(raddr); rs = 0; end
        else rvcnt--;
      end else begin
        if (rs == 0 && bus.mem_req) begin
          rs = 1; cnt = (fixed_gnt >= 0) ? fixed_gnt : int'($urandom_range(0, 3));
        end
        if (rs == 1) begin
          if (!bus.mem_req) rs = 0;
          else begin
            check_val("req_in_rdy", {63'd0, in_ready}, 64'd0);
            if (bus_q.size() == 0) check_val("bus_spurious", {63'd0, bus.mem_req}, 64'd0);
            else begin
              be = bus_q[0];
              check_val("bus_addr", bus.mem_addr, be.addr);
              check_val("bus_we", {63'd0, bus.mem_we}, {63'd0, be.we});
              if (be.we) begin
                check_val("bus_wmask", {56'd0, bus.mem_wmask}, {56'd0, be.wmask});
                check_val("bus_wdata", bus.mem_wdata, be.wdata);
              end
            end
            if (cnt == 0) begin
              bus.mem_gnt = 1; raddr = bus.mem_addr; last_addr = bus.mem_addr;
              last_wmask = bus.mem_wmask; last_wdata = bus.mem_wdata;
              if (bus_q.size() > 0) be = bus_q.pop_front();
              if (bus.mem_we) rs = 0;
              else begin rs = 2; rvcnt = (fixed_rv >= 0) ? fixed_rv : int'($urandom_range(0, 3)); end
            end else cnt--;
          end
        end
      end
    end
  end

  // ---------------- write-back side ----------------
  initial begin
    int hold; bit held; out_exp_t oe;
    hold = 0; held = 0; out_ready = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin hold = 0; held = 0; end
      if (rdy_low_next > 0 && out_valid) begin hold = rdy_low_next; rdy_low_next = 0; end
      if (hold > 0) begin out_ready = 0; hold--; end
      else if (force_rdy) out_ready = 1;
      else out_ready = (($urandom % 4) != 0);
      @(negedge clk);
      if (held && rst_n) check_val("out_hold_vld", {63'd0, out_valid}, 64'd1);
      held = 0;
      if (out_valid && out_ready) begin
        if (out_q.size() == 0) check_val("out_spurious", {63'd0, out_valid}, 64'd0);
        else begin
          oe = out_q.pop_front();
          check_val("out_data", out_data, oe.data);
          check_val("out_rd", {59'd0, out_rd}, {59'd0, oe.rd});
          check_val("out_wen", {63'd0, out_wen}, {63'd0, oe.wen});
`ifdef YSYX_22041412_LSU_MISALIGN_EN
          check_val("out_mis", {63'd0, out_misalign}, {63'd0, oe.mis});
`endif
          last_out_data = out_data; last_out_wen = out_wen;
        end
      end else if (out_valid) begin
        held = 1;
        check_val("stall_in_rdy", {63'd0, in_ready}, 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int b; logic [2:0] f3; logic [63:0] a;
    rst_n = 0; in_valid = 0; in_opcode = '0; in_func3 = '0; in_result = '0; in_sdata = '0; in_rd = '0;
    repeat (3) @(posedge clk); #1;
    check_val("rst_req", {63'd0, bus.mem_req}, 64'd0);
    check_val("rst_we", {63'd0, bus.mem_we}, 64'd0);
    check_val("rst_addr", bus.mem_addr, 64'd0);
    check_val("rst_wdata", bus.mem_wdata, 64'd0);
    check_val("rst_wmask", {56'd0, bus.mem_wmask}, 64'd0);
    check_val("rst_out_vld", {63'd0, out_valid}, 64'd0);
    check_val("rst_out_wen", {63'd0, out_wen}, 64'd0);
    check_val("rst_out_data", out_data, 64'd0);
    check_val("rst_out_rd", {59'd0, out_rd}, 64'd0);
    check_val("rst_in_rdy", {63'd0, in_ready}, 64'd1);
    #2 rst_n = 1;
    @(posedge clk); #1;

    // non-mem pass-through
    force_rdy = 1;
    send(7'b0110011, 3'b000, 64'h1234, 64'h0, 5'd5);
    wait_drain();
    check_val("t1_data", last_out_data, 64'h1234);
    check_val("t1_wen", {63'd0, last_out_wen}, 64'd1);

    // LB sign-extends the top bit of byte 3
    use_fixed = 1; fixed_rdata = 64'h0000_0000_8000_0000;
    send(LD, 3'b000, 64'h8000_0003, 64'h0, 5'd6);
    wait_drain();
    check_val("t2_addr", last_addr, 64'h8000_0000);
    check_val("t2_data", last_out_data, 64'hFFFF_FFFF_FFFF_FF80);

    // LHU from the top half-word
    fixed_rdata = 64'hBEEF_0000_0000_0000;
    send(LD, 3'b101, 64'h8000_0006, 64'h0, 5'd7);
    wait_drain();
    check_val("t3_data", last_out_data, 64'h0000_0000_0000_BEEF);
    use_fixed = 0;

    // SW into the upper word
    send(ST, 3'b010, 64'h8000_0004, 64'h1122_3344, 5'd8);
    wait_drain();
    check_val("t4_wmask", {56'd0, last_wmask}, 64'h00F0);
    check_val("t4_wdata", last_wdata, 64'h1122_3344_0000_0000);
    check_val("t4_wen", {63'd0, last_out_wen}, 64'd0);

    // long grant wait then write-back stall
    force_rdy = 0; fixed_gnt = 5; rdy_low_next = 3;
    send(LD, 3'b011, 64'h8000_0040, 64'h0, 5'd9);
    wait_drain();
    fixed_gnt = -1;

    // reset while the request is pending: mem_req drops without a clock edge
    fixed_gnt = 30;
    send(LD, 3'b011, 64'h8000_0010, 64'h0, 5'd10);
    #2 rst_n = 0;
    #1;
    check_val("r_req_drop", {63'd0, bus.mem_req}, 64'd0);
    check_val("r_req_outv", {63'd0, out_valid}, 64'd0);
    check_val("r_req_inrdy", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #3 rst_n = 1;
    out_q.delete(); bus_q.delete(); fixed_gnt = -1;
    @(posedge clk); #1;

    // reset while waiting for read data; the late rvalid must be ignored
    fixed_gnt = 0; fixed_rv = 6;
    send(LD, 3'b010, 64'h8000_0020, 64'h0, 5'd11);
    b = 0;
    while (rs != 2 && b < 20) begin @(posedge clk); #1; b++; end
    if (b >= 20) check_val("r_wait_reach", 64'(rs), 64'd2);
    @(posedge clk); #1;
    check_val("r_wait_inrdy0", {63'd0, in_ready}, 64'd0);
    #1 rst_n = 0;
    #1;
    check_val("r_wait_req", {63'd0, bus.mem_req}, 64'd0);
    check_val("r_wait_outv", {63'd0, out_valid}, 64'd0);
    check_val("r_wait_inrdy1", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #3 rst_n = 1;
    out_q.delete(); bus_q.delete(); fixed_gnt = -1; fixed_rv = -1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check_val("r_no_out", {63'd0, out_valid}, 64'd0);
    end

    // randomized mix, including back-to-back accepts
    for (int i = 0; i < 300; i++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      a = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFF)};
      case ($urandom % 3)
        0: send(($urandom % 2) ? 7'b0110011 : 7'b0010011, 3'($urandom), {$urandom, $urandom},
                {$urandom, $urandom}, 5'($urandom));
        1: begin f3 = 3'($urandom % 7); send(LD, f3, a, {$urandom, $urandom}, 5'($urandom)); end
        default: begin f3 = 3'($urandom % 4); send(ST, f3, a, {$urandom, $urandom}, 5'($urandom)); end
      endcase
    end
    wait_drain();

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
